// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU/divider: op codes, FSM states and a
// ceiling-log2 helper used to size the division iteration counter.
package seq_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_XOR  = 3'b011,
    OP_SHR  = 3'b100,
    OP_SHL  = 3'b101,
    OP_DIV  = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_alu_div_nrd_step.sv
// One combinational non-restoring division iteration: shift {P,Q} left by one,
// then subtract or add the divisor depending on the sign of the shifted P.
module nrd_step #(
  parameter int WIDTH = 8
) (
  input  logic signed [WIDTH:0]   p_i,
  input  logic        [WIDTH-1:0] q_i,
  input  logic        [WIDTH-1:0] b_i,
  output logic signed [WIDTH:0]   p_o,
  output logic        [WIDTH-1:0] q_o
);

  logic signed [WIDTH:0]   p_sh;
  logic signed [WIDTH:0]   b_ext;
  logic        [WIDTH-1:0] q_sh;

  always_comb begin
    p_sh  = $signed({p_i[WIDTH-1:0], q_i[WIDTH-1]});
    q_sh  = {q_i[WIDTH-2:0], 1'b0};
    b_ext = $signed({1'b0, b_i});
    p_o   = p_sh[WIDTH] ? (p_sh + b_ext) : (p_sh - b_ext);
    q_o   = {q_sh[WIDTH-1:1], ~p_o[WIDTH]};
  end

endmodule

// File: rtl/seq_alu_div.sv
// Registered ALU with valid/ready handshake and optional multi-cycle unsigned
// non-restoring divider, compiled in when ALU_DIV_EN is defined.
module seq_alu_div
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] rem,
  output logic             co,
  output logic             z,
  output logic             n,
  output logic             dz,
  output logic             ill_op
);

  state_e           state_q, state_d;
  op_e              op_in;
  logic             accept;
  logic             div_go;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] result_q, result_d;
  logic             co_q, co_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic             ill_q, ill_d;

`ifdef ALU_DIV_EN
  localparam int CNT_W = clog2(WIDTH);

  logic [WIDTH-1:0]      rem_q, rem_d;
  logic                  dz_q, dz_d;
  logic [WIDTH-1:0]      b_q, b_d;
  logic [WIDTH-1:0]      q_q, q_d, q_step;
  logic signed [WIDTH:0] p_q, p_d, p_step, p_fix;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  cnt_last;

  nrd_step #(.WIDTH(WIDTH)) u_nrd_step (
    .p_i (p_q),
    .q_i (q_q),
    .b_i (b_q),
    .p_o (p_step),
    .q_o (q_step)
  );

  assign cnt_last = (cnt_q == CNT_W'(WIDTH - 1));
  assign div_go   = (op_in == OP_DIV) && (b != '0);
  assign rem      = rem_q;
  assign dz       = dz_q;
`else
  assign div_go   = 1'b0;
  assign rem      = '0;
  assign dz       = 1'b0;
`endif

  assign op_in  = op_e'(op);
  assign accept = in_valid && in_ready;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_d = div_go ? S_ITER : S_HOLD;
`ifdef ALU_DIV_EN
      S_ITER: if (cnt_last) state_d = S_FIX;
      S_FIX:  state_d = S_HOLD;
`endif
      S_HOLD: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_HOLD);
  end

  // Result and flag capture: single-cycle ops on accept, DIV on the FIX cycle
  always_comb begin
    result_d = result_q;
    co_d     = co_q;
    ill_d    = ill_q;
    sum      = '0;
`ifdef ALU_DIV_EN
    rem_d    = rem_q;
    dz_d     = dz_q;
`endif
    if (accept) begin
      result_d = '0;
      co_d     = 1'b0;
      ill_d    = 1'b0;
`ifdef ALU_DIV_EN
      rem_d    = '0;
      dz_d     = 1'b0;
`endif
      case (op_in)
        OP_ADD: begin
          sum = {1'b0, a} + {1'b0, b};
          {co_d, result_d} = sum;
        end
        OP_SUB: begin
          sum = {1'b0, a} + {1'b0, ~b} + (WIDTH + 1)'(1);
          {co_d, result_d} = sum;
        end
        OP_AND: result_d = a & b;
        OP_XOR: result_d = a ^ b;
        OP_SHR: begin
          result_d = a >> 1;
          co_d     = a[0];
        end
        OP_SHL: begin
          result_d = a << 1;
          co_d     = a[WIDTH-1];
        end
`ifdef ALU_DIV_EN
        OP_DIV: begin
          if (b == '0) begin
            result_d = '1;
            rem_d    = a;
            dz_d     = 1'b1;
          end
        end
`endif
        default: ill_d = 1'b1;
      endcase
    end
`ifdef ALU_DIV_EN
    else if (state_q == S_FIX) begin
      result_d = q_q;
      rem_d    = p_fix[WIDTH-1:0];
      co_d     = 1'b0;
    end
`endif
    z_d = (result_d == '0);
    n_d = result_d[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      co_q     <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      co_q     <= co_d;
      z_q      <= z_d;
      n_q      <= n_d;
      ill_q    <= ill_d;
    end
  end

`ifdef ALU_DIV_EN
  // Divider iteration state; P/Q/b carry no reset since the counter and FSM gate their use
  always_comb begin
    p_d   = p_q;
    q_d   = q_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    if (accept) begin
      p_d   = '0;
      q_d   = a;
      b_d   = b;
      cnt_d = '0;
    end else if (state_q == S_ITER) begin
      p_d   = p_step;
      q_d   = q_step;
      cnt_d = cnt_q + CNT_W'(1);
    end
    p_fix = p_q[WIDTH] ? (p_q + $signed({1'b0, b_q})) : p_q;
  end

  always_ff @(posedge clk) begin
    p_q <= p_d;
    q_q <= q_d;
    b_q <= b_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      rem_q <= '0;
      dz_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      dz_q  <= dz_d;
    end
  end
`endif

  assign result = result_q;
  assign co     = co_q;
  assign z      = z_q;
  assign n      = n_q;
  assign ill_op = ill_q;

endmodule

// File: tb/tb_seq_alu_div.sv
// Directed self-checking bench for seq_alu_div (WIDTH=8); DIV scenarios are
// exercised when ALU_DIV_EN is defined, the illegal-op fallback otherwise.
module tb_seq_alu_div;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] rem;
  logic         co, z, n, dz, ill_op;

  int checks;
  int fails;

  seq_alu_div #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .rem       (rem),
    .co        (co),
    .z         (z),
    .n         (n),
    .dz        (dz),
    .ill_op    (ill_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_op(input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb);
    @(negedge clk);
    op       = o;
    a        = aa;
    b        = bb;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Latency counted in clock edges from the accept edge to out_valid
  task automatic wait_valid(output int lat);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({out_valid, result, rem, co, z, n, dz, ill_op} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got ov=%b res=%h rem=%h flags=%b, need all 0",
               out_valid, result, rem, {co, z, n, dz, ill_op});
    end
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b need 1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_sub();
    int lat;
    start_op(3'b000, 8'hF0, 8'h20);
    wait_valid(lat);
    checks++;
    if (lat !== 1) begin fails++; $display("FAIL add_latency: got %0d need 1", lat); end
    checks++;
    if ({result, rem, co, z, n, dz, ill_op} !== {8'h10, 8'h00, 5'b10000}) begin
      fails++;
      $display("FAIL add_f0_20: got res=%h rem=%h flags=%b need res=10 rem=00 flags=10000",
               result, rem, {co, z, n, dz, ill_op});
    end
    release_out();
    start_op(3'b001, 8'h05, 8'h05);
    wait_valid(lat);
    checks++;
    if ({result, co, z, n} !== {8'h00, 3'b110}) begin
      fails++;
      $display("FAIL sub_5_5: got res=%h co/z/n=%b need res=00 co/z/n=110", result, {co, z, n});
    end
    release_out();
  endtask

  task automatic test_logic_shift();
    int lat;
    start_op(3'b010, 8'hF0, 8'h3C);
    wait_valid(lat);
    checks++;
    if ({result, co, z, n} !== {8'h30, 3'b000}) begin
      fails++;
      $display("FAIL and: got res=%h co/z/n=%b need res=30 co/z/n=000", result, {co, z, n});
    end
    release_out();
    start_op(3'b011, 8'hF0, 8'h3C);
    wait_valid(lat);
    checks++;
    if ({result, co, z, n} !== {8'hCC, 3'b001}) begin
      fails++;
      $display("FAIL xor: got res=%h co/z/n=%b need res=cc co/z/n=001", result, {co, z, n});
    end
    release_out();
    start_op(3'b100, 8'h81, 8'h00);
    wait_valid(lat);
    checks++;
    if ({result, co, z, n} !== {8'h40, 3'b100}) begin
      fails++;
      $display("FAIL shr_81: got res=%h co/z/n=%b need res=40 co/z/n=100", result, {co, z, n});
    end
    release_out();
    start_op(3'b101, 8'h81, 8'h00);
    wait_valid(lat);
    checks++;
    if ({result, co, z, n} !== {8'h02, 3'b100}) begin
      fails++;
      $display("FAIL shl_81: got res=%h co/z/n=%b need res=02 co/z/n=100", result, {co, z, n});
    end
    release_out();
  endtask

  task automatic test_div();
    int lat;
`ifdef ALU_DIV_EN
    start_op(3'b110, 8'd100, 8'd7);
    wait_valid(lat);
    checks++;
    if (lat !== 10) begin fails++; $display("FAIL div_latency: got %0d need 10", lat); end
    checks++;
    if ({result, rem, co, z, n, dz, ill_op} !== {8'd14, 8'd2, 5'b00000}) begin
      fails++;
      $display("FAIL div_100_7: got q=%0d r=%0d flags=%b need q=14 r=2 flags=00000",
               result, rem, {co, z, n, dz, ill_op});
    end
    release_out();
    start_op(3'b110, 8'hFF, 8'h01);
    wait_valid(lat);
    checks++;
    if ({result, rem, co, z, n, dz, ill_op} !== {8'hFF, 8'h00, 5'b00100}) begin
      fails++;
      $display("FAIL div_ff_1: got q=%h r=%h flags=%b need q=ff r=00 flags=00100",
               result, rem, {co, z, n, dz, ill_op});
    end
    release_out();
    start_op(3'b110, 8'h37, 8'h00);
    wait_valid(lat);
    checks++;
    if (lat !== 1) begin fails++; $display("FAIL divzero_latency: got %0d need 1", lat); end
    checks++;
    if ({result, rem, co, z, n, dz, ill_op} !== {8'hFF, 8'h37, 5'b00110}) begin
      fails++;
      $display("FAIL divzero: got q=%h r=%h flags=%b need q=ff r=37 flags=00110",
               result, rem, {co, z, n, dz, ill_op});
    end
    release_out();
`else
    start_op(3'b110, 8'd100, 8'd7);
    wait_valid(lat);
    checks++;
    if (lat !== 1) begin fails++; $display("FAIL nodiv_latency: got %0d need 1", lat); end
    checks++;
    if ({result, rem, co, z, n, dz, ill_op} !== {8'h00, 8'h00, 5'b01001}) begin
      fails++;
      $display("FAIL nodiv_op110: got res=%h rem=%h flags=%b need res=00 rem=00 flags=01001",
               result, rem, {co, z, n, dz, ill_op});
    end
    release_out();
`endif
  endtask

  task automatic test_illegal();
    int lat;
    start_op(3'b111, 8'hAA, 8'h55);
    wait_valid(lat);
    checks++;
    if ({result, rem, co, z, n, dz, ill_op} !== {8'h00, 8'h00, 5'b01001}) begin
      fails++;
      $display("FAIL op111: got res=%h rem=%h flags=%b need res=00 rem=00 flags=01001",
               result, rem, {co, z, n, dz, ill_op});
    end
    release_out();
    start_op(3'b000, 8'h01, 8'h01);
    wait_valid(lat);
    checks++;
    if ({result, dz, ill_op} !== {8'h02, 2'b00}) begin
      fails++;
      $display("FAIL ill_clear: got res=%h dz/ill=%b need res=02 dz/ill=00", result, {dz, ill_op});
    end
    release_out();
  endtask

  task automatic test_hold();
    int lat;
    int bad;
    start_op(3'b000, 8'h01, 8'h02);
    wait_valid(lat);
    bad = 0;
    op       = 3'b011;
    a        = 8'hFF;
    b        = 8'h0F;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 8'h03 ||
          {co, z, n, dz, ill_op} !== 5'b00000) bad++;
    end
    checks++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL hold_stable: got %0d unstable cycles, last res=%h ov=%b ir=%b need 0",
               bad, result, out_valid, in_ready);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      fails++;
      $display("FAIL hold_release: got ir/ov=%b need 10", {in_ready, out_valid});
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      fails++;
      $display("FAIL hold_ignored_op: got ir/ov=%b need 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_reset_mid_div();
`ifdef ALU_DIV_EN
    int seen;
    start_op(3'b110, 8'd100, 8'd7);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, result, rem, co, z, n, dz, ill_op} !== '0) begin
      fails++;
      $display("FAIL reset_mid_div: got ov=%b res=%h rem=%h flags=%b need all 0",
               out_valid, result, rem, {co, z, n, dz, ill_op});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_div_ready: got %b need 1", in_ready);
    end
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL reset_mid_div_noresult: got out_valid in %0d cycles need 0", seen);
    end
`endif
  endtask

  initial begin
    checks    = 0;
    fails     = 0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = 3'b000;
    a         = '0;
    b         = '0;
    test_reset();
    test_add_sub();
    test_logic_shift();
    test_div();
    test_illegal();
    test_hold();
    test_reset_mid_div();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
